// File: rtl/mem_wb_sequencer.sv
// rtl/mem_wb_sequencer.sv - back-end sequencer for data-memory handshake, register write-back and branch pulse
module mem_wb_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemToReg,
  input  logic              Branch,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              br_taken,
  output logic              err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alu_q      <= '0;
      rdata_q    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      br_taken   <= 1'b0;
      err        <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      br_taken <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            regwrite_q <= RegWrite;
            memtoreg_q <= MemToReg;
            alu_q      <= alu_result;
            mem_addr   <= alu_result[ADDR_W-1:0];
            mem_wdata  <= store_data;
            mem_we     <= MemWrite;
            rf_waddr   <= rd;
            if (MemRead && MemWrite) begin
              err <= 1'b1;
            end else if (MemRead || MemWrite) begin
              state    <= MEM;
              mem_req  <= 1'b1;
              wait_cnt <= '0;
            end else if (RegWrite) begin
              state    <= WB;
              rf_we    <= (rd != 5'd0);
              rf_wdata <= MemToReg ? rdata_q : alu_result;
            end else begin
              br_taken <= Branch & alu_zero;
            end
          end
        end
        MEM: begin
          // an ack in the final allowed cycle still wins over the timeout
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata_q <= mem_rdata;
              if (regwrite_q) begin
                state    <= WB;
                rf_we    <= (rf_waddr != 5'd0);
                rf_wdata <= memtoreg_q ? mem_rdata : alu_q;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= IDLE;
            end
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// tb/tb_mem_wb_sequencer.sv - randomized self-checking bench with cycle-timeline reference model
module tb_mem_wb_sequencer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready;
  logic          RegWrite, MemRead, MemWrite, MemToReg, Branch, alu_zero;
  logic [DW-1:0] alu_result, store_data, mem_wdata, mem_rdata, rf_wdata;
  logic [AW-1:0] mem_addr;
  logic [4:0]    rd, rf_waddr;
  logic          mem_req, mem_we, mem_ack, rf_we, br_taken, err;

  mem_wb_sequencer #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .Branch(Branch), .alu_result(alu_result),
    .alu_zero(alu_zero), .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .br_taken(br_taken), .err(err)
  );

  typedef struct {
    logic rw, mr, mw, m2r, br, zero;
    logic [31:0] alu, sd, rdata;
    logic [4:0]  rd;
    int          delay;
  } bundle_t;

  typedef struct {
    logic          in_ready, mem_req, mem_we, rf_we, br_taken, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rf_wdata;
    logic [4:0]    rf_waddr;
  } exp_t;

  int   cyc = 0;
  int   free_cyc = 0;
  bit   checking = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [int];
  bit   mem_cyc [int];
  logic [31:0] ack_rd [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t e;
    e.in_ready = 1'b1; e.mem_req = 1'b0; e.mem_we = 1'b0; e.rf_we = 1'b0;
    e.br_taken = 1'b0; e.err = 1'b0; e.mem_addr = '0; e.mem_wdata = '0;
    e.rf_wdata = '0; e.rf_waddr = '0;
    return e;
  endfunction

  function automatic bundle_t mk(input bit rw, mr, mw, m2r, br, zero,
                                 input logic [31:0] alu, sd, input logic [4:0] r,
                                 input int delay, input logic [31:0] rdata);
    bundle_t b;
    b.rw = rw; b.mr = mr; b.mw = mw; b.m2r = m2r; b.br = br; b.zero = zero;
    b.alu = alu; b.sd = sd; b.rd = r; b.delay = delay; b.rdata = rdata;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int r;
    b.rw = 1'($urandom_range(0, 1)); b.br = 1'($urandom_range(0, 1));
    b.zero = 1'($urandom_range(0, 1));
    b.mr = ($urandom_range(0, 2) == 0); b.mw = ($urandom_range(0, 2) == 0);
    b.m2r = b.mr ? 1'($urandom_range(0, 1)) : 1'b0;
    b.alu = $urandom; b.sd = $urandom; b.rdata = $urandom;
    b.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r = $urandom_range(0, 9);
    b.delay = (r < 8) ? (r % 4) : 20;
    return b;
  endfunction

  // Timeline model: an accept at the edge ending cycle k lays out the expected outputs for cycles k+1..
  task automatic model_accept(input int k, input bundle_t b);
    exp_t e;
    int n;
    e = idle_rec();
    if (b.mr && b.mw) begin
      e.err = 1'b1; exp_q[k+1] = e; free_cyc = k + 1;
    end else if (b.mr || b.mw) begin
      n = (b.delay >= TO) ? TO : b.delay + 1;
      for (int j = 1; j <= n; j++) begin
        e = idle_rec(); e.in_ready = 1'b0; e.mem_req = 1'b1; e.mem_we = b.mw;
        e.mem_addr = b.alu; e.mem_wdata = b.sd;
        exp_q[k+j] = e; mem_cyc[k+j] = 1'b1;
      end
      if (b.delay >= TO) begin
        e = idle_rec(); e.err = 1'b1; exp_q[k+n+1] = e; free_cyc = k + n + 1;
      end else begin
        ack_rd[k+n] = b.rdata;
        if (b.mr && b.rw) begin
          e = idle_rec(); e.in_ready = 1'b0; e.rf_we = (b.rd != 5'd0);
          e.rf_waddr = b.rd; e.rf_wdata = b.m2r ? b.rdata : b.alu;
          exp_q[k+n+1] = e; free_cyc = k + n + 2;
        end else begin
          free_cyc = k + n + 1;
        end
      end
    end else if (b.rw) begin
      e.in_ready = 1'b0; e.rf_we = (b.rd != 5'd0); e.rf_waddr = b.rd; e.rf_wdata = b.alu;
      exp_q[k+1] = e; free_cyc = k + 2;
    end else begin
      e.br_taken = b.br & b.zero; exp_q[k+1] = e; free_cyc = k + 1;
    end
  endtask

  task automatic drive_bundle(input bundle_t b);
    RegWrite = b.rw; MemRead = b.mr; MemWrite = b.mw; MemToReg = b.m2r;
    Branch = b.br; alu_zero = b.zero; alu_result = b.alu; store_data = b.sd; rd = b.rd;
  endtask

  task automatic step(input bit offer, input bundle_t b, input bit do_rst, input bit force_ack);
    int k;
    k = cyc;
    rst_n = !do_rst;
    mem_rdata = $urandom;
    if (ack_rd.exists(k)) begin
      mem_ack = 1'b1; mem_rdata = ack_rd[k];
    end else if (mem_cyc.exists(k)) begin
      mem_ack = 1'b0;
    end else begin
      mem_ack = force_ack | 1'($urandom_range(0, 1));
    end
    drive_bundle(rand_bundle());
    in_valid = 1'b0;
    if (do_rst) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int i = k + 1; i <= k + 64; i++) begin
        if (exp_q.exists(i)) exp_q.delete(i);
        if (mem_cyc.exists(i)) mem_cyc.delete(i);
        if (ack_rd.exists(i)) ack_rd.delete(i);
      end
      free_cyc = k + 1;
    end else if (k >= free_cyc) begin
      if (offer) begin
        drive_bundle(b); in_valid = 1'b1; model_accept(k, b);
      end
    end else begin
      in_valid = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      exp_t e;
      e = exp_q.exists(cyc) ? exp_q[cyc] : idle_rec();
      check("in_ready", in_ready, e.in_ready);
      check("mem_req", mem_req, e.mem_req);
      check("rf_we", rf_we, e.rf_we);
      check("br_taken", br_taken, e.br_taken);
      check("err", err, e.err);
      if (e.mem_req) begin
        check("mem_we", mem_we, e.mem_we);
        check("mem_addr", mem_addr, e.mem_addr);
        check("mem_wdata", mem_wdata, e.mem_wdata);
      end
      if (e.rf_we) begin
        check("rf_waddr", rf_waddr, e.rf_waddr);
        check("rf_wdata", rf_wdata, e.rf_wdata);
      end
    end
  end

  initial begin
    bundle_t nb;
    int n;
    nb = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, nb, 1, 0);
    check("rst_in_ready", in_ready, 1); check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rf_wdata", rf_wdata, 0); check("rst_rf_waddr", rf_waddr, 0);
    check("rst_err", err, 0);
    checking = 1'b1;
    step(0, nb, 0, 0);

    step(1, mk(1, 0, 0, 0, 0, 0, 32'h1234, 0, 5, 0, 0), 0, 0);
    check("rtype_rf_we", rf_we, 1); check("rtype_waddr", rf_waddr, 5);
    check("rtype_wdata", rf_wdata, 32'h1234); check("rtype_busy", in_ready, 0);
    step(0, nb, 0, 0);
    check("rtype_ready", in_ready, 1);

    step(1, mk(1, 1, 0, 1, 0, 0, 32'h40, 0, 7, 2, 32'hDEADBEEF), 0, 0);
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      check("ld_addr", mem_addr, 32'h40); check("ld_we", mem_we, 0);
      step(0, nb, 0, 0);
    end
    check("ld_req_cycles", n, 3);
    check("ld_rf_we", rf_we, 1); check("ld_wdata", rf_wdata, 32'hDEADBEEF);
    check("ld_waddr", rf_waddr, 7);
    step(0, nb, 0, 0);

    step(1, mk(0, 0, 1, 0, 0, 0, 32'h80, 32'hA5A5, 3, 0, 0), 0, 0);
    check("st_we", mem_we, 1); check("st_wdata", mem_wdata, 32'hA5A5);
    check("st_addr", mem_addr, 32'h80);
    step(0, nb, 0, 0);
    check("st_no_rf_we", rf_we, 0); check("st_ready", in_ready, 1);

    step(1, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 0, 0);
    check("br1_taken", br_taken, 1); check("br1_ready", in_ready, 1);
    step(1, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    check("br2_taken", br_taken, 0); check("br2_ready", in_ready, 1);

    step(1, mk(1, 1, 0, 1, 0, 0, 32'h44, 0, 9, 99, 0), 0, 0);
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      step(0, nb, 0, 0);
    end
    check("to_req_cycles", n, TO);
    check("to_err", err, 1); check("to_no_rf_we", rf_we, 0);
    step(0, nb, 0, 0);
    check("to_err_once", err, 0); check("to_no_rf_we2", rf_we, 0);

    step(1, mk(1, 1, 1, 0, 0, 0, 32'h48, 0, 4, 0, 0), 0, 0);
    check("ill_err", err, 1); check("ill_no_req", mem_req, 0);
    step(0, nb, 0, 0);
    check("ill_no_req2", mem_req, 0); check("ill_no_rf_we", rf_we, 0);

    step(1, mk(1, 1, 0, 1, 0, 0, 32'h50, 0, 6, 5, 32'h12345678), 0, 0);
    step(0, nb, 0, 0);
    check("rst_mid_req", mem_req, 1);
    step(0, nb, 1, 0);
    check("rst_abort_req", mem_req, 0); check("rst_abort_ready", in_ready, 1);
    repeat (4) begin
      step(0, nb, 0, 1);
      check("rst_late_ack_rf_we", rf_we, 0); check("rst_late_ack_req", mem_req, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) step(0, nb, 1, 0);
      else step($urandom_range(0, 9) < 6, rand_bundle(), 0, 0);
    end
    repeat (20) step(0, nb, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
